// File: rtl/pll_phase_ctrl.sv
// pll_phase_ctrl: ECP5 EHXPLLL dynamic phase-step sequencer with per-channel offset tracking.
// Define PLL_PHASE_CTRL_LOCKMON_EN for lock-stable reset qualification and sequence abort.
module pll_phase_ctrl #(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned STEPS_W     = 8,
    parameter int unsigned PHASE_W     = 6,
    parameter int unsigned SETUP_CYC   = 2,
    parameter int unsigned PULSE_CYC   = 2,
    parameter int unsigned GAP_CYC     = 4,
    parameter int unsigned LOCK_STABLE = 1024
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmd_valid_i,
    output logic               cmd_ready_o,
    input  logic [1:0]         cmd_ch_i,
    input  logic               cmd_dir_i,
    input  logic [STEPS_W-1:0] cmd_steps_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               cmd_err_o,
    input  logic [1:0]         phase_rd_ch_i,
    output logic [PHASE_W-1:0] phase_rd_o,
    input  logic               pll_locked_i,
    output logic [1:0]         pll_phasesel_o,
    output logic               pll_phasedir_o,
    output logic               pll_phasestep_o,
    output logic               pll_phaseloadreg_o,
    output logic               rst_out_n_o,
    output logic               lock_lost_o
);

    localparam int unsigned MaxSp  = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
    localparam int unsigned TmrMax = (MaxSp > GAP_CYC) ? MaxSp : GAP_CYC;
    localparam int unsigned TmrW   = $clog2(TmrMax + 1);

    if (SETUP_CYC == 0 || PULSE_CYC == 0 || GAP_CYC == 0 || LOCK_STABLE == 0) begin : g_bad_cfg
        $error("pll_phase_ctrl: cycle parameters must be >= 1");
    end

    typedef enum logic [2:0] {StIdle, StSetup, StStepLo, StStepHi, StLoad, StDone} state_e;

    state_e              state_q, state_d;
    logic [TmrW-1:0]     tmr_q, tmr_d;
    logic [STEPS_W-1:0]  rem_q, rem_d;
    logic [1:0]          sel_q, sel_d;
    logic                dir_q, dir_d;
    logic                err_q, err_d;
    logic                armed_q;
    logic [1:0]          sync_q;
    logic [PHASE_W-1:0]  acc_q [4];
    logic                acc_upd;
    logic                locked_s;
    logic                lock_ok;
    logic                hs;

    assign locked_s    = sync_q[1];
    assign cmd_ready_o = (state_q == StIdle) && armed_q && lock_ok;
    assign hs          = cmd_valid_i && cmd_ready_o;

    // Busy covers the handshake cycle itself through the done cycle.
    assign busy_o             = (state_q != StIdle) || hs;
    assign done_o             = (state_q == StDone);
    assign cmd_err_o          = done_o && err_q;
    assign pll_phasestep_o    = (state_q != StStepLo);
    assign pll_phaseloadreg_o = (state_q != StLoad);
    assign pll_phasesel_o     = sel_q;
    assign pll_phasedir_o     = dir_q;
    assign phase_rd_o         = (32'(phase_rd_ch_i) < NUM_CH) ? acc_q[phase_rd_ch_i] : '0;

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        rem_d   = rem_q;
        sel_d   = sel_q;
        dir_d   = dir_q;
        err_d   = err_q;
        acc_upd = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (hs) begin
                    err_d = 1'b0;
                    rem_d = cmd_steps_i;
                    if (32'(cmd_ch_i) >= NUM_CH) begin
                        state_d = StDone;
                        err_d   = 1'b1;
                    end else if (cmd_steps_i == '0) begin
                        state_d = StDone;
                    end else begin
                        state_d = StSetup;
                        tmr_d   = TmrW'(SETUP_CYC - 1);
                        sel_d   = cmd_ch_i;
                        dir_d   = cmd_dir_i;
                    end
                end
            end
            StSetup: begin
                if (tmr_q == '0) begin
                    state_d = StStepLo;
                    tmr_d   = TmrW'(PULSE_CYC - 1);
                end else begin
                    tmr_d = tmr_q - TmrW'(1);
                end
            end
            StStepLo: begin
                if (tmr_q == '0) begin
                    state_d = StStepHi;
                    tmr_d   = TmrW'(GAP_CYC - 1);
                    rem_d   = rem_q - STEPS_W'(1);
                    acc_upd = 1'b1;
                end else begin
                    tmr_d = tmr_q - TmrW'(1);
                end
            end
            StStepHi: begin
                if (tmr_q == '0) begin
                    state_d = (rem_q != '0) ? StStepLo : StLoad;
                    tmr_d   = TmrW'(PULSE_CYC - 1);
                end else begin
                    tmr_d = tmr_q - TmrW'(1);
                end
            end
            StLoad: begin
                if (tmr_q == '0) begin
                    state_d = StDone;
                end else begin
                    tmr_d = tmr_q - TmrW'(1);
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
`ifdef PLL_PHASE_CTRL_LOCKMON_EN
        // A pulse cut short by lock loss is not counted in the accumulator.
        if (!locked_s && state_q != StIdle && state_q != StDone) begin
            state_d = StDone;
            err_d   = 1'b1;
            rem_d   = rem_q;
            acc_upd = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            tmr_q   <= '0;
            rem_q   <= '0;
            sel_q   <= '0;
            dir_q   <= 1'b0;
            err_q   <= 1'b0;
            armed_q <= 1'b0;
            sync_q  <= '0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            rem_q   <= rem_d;
            sel_q   <= sel_d;
            dir_q   <= dir_d;
            err_q   <= err_d;
            armed_q <= 1'b1;
            sync_q  <= {sync_q[0], pll_locked_i};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) acc_q[i] <= '0;
        end else if (acc_upd) begin
            acc_q[sel_q] <= dir_q ? acc_q[sel_q] + PHASE_W'(1) : acc_q[sel_q] - PHASE_W'(1);
        end
    end

`ifdef PLL_PHASE_CTRL_LOCKMON_EN
    localparam int unsigned LckW = $clog2(LOCK_STABLE + 1);

    logic [LckW-1:0] lck_cnt_q;
    logic            rst_out_q;
    logic            lost_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lck_cnt_q <= '0;
            rst_out_q <= 1'b0;
            lost_q    <= 1'b0;
        end else if (!locked_s) begin
            lck_cnt_q <= '0;
            rst_out_q <= 1'b0;
            lost_q    <= lost_q | rst_out_q;
        end else if (!rst_out_q) begin
            if (lck_cnt_q == LckW'(LOCK_STABLE - 1)) begin
                rst_out_q <= 1'b1;
            end else begin
                lck_cnt_q <= lck_cnt_q + LckW'(1);
            end
        end
    end

    assign rst_out_n_o = rst_out_q;
    assign lock_lost_o = lost_q;
    assign lock_ok     = rst_out_q;
`else
    assign rst_out_n_o = locked_s;
    assign lock_lost_o = 1'b0;
    assign lock_ok     = 1'b1;
`endif

endmodule

// File: tb/tb_pll_phase_ctrl.sv
// Scoreboarded bench for pll_phase_ctrl: random phase commands against an arithmetic phase model.
// Follows PLL_PHASE_CTRL_LOCKMON_EN to pick the expected lock/abort behaviour.
module tb_pll_phase_ctrl;

    localparam int NCH   = 3;
    localparam int SETUP = 2;
    localparam int PULSE = 2;
    localparam int GAP   = 4;
    localparam int LS    = 64;
`ifdef PLL_PHASE_CTRL_LOCKMON_EN
    localparam bit LOCKMON = 1'b1;
`else
    localparam bit LOCKMON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_ch = '0;
    logic       cmd_dir = 1'b0;
    logic [7:0] cmd_steps = '0;
    logic       busy, done, cmd_err;
    logic [1:0] phase_rd_ch = '0;
    logic [5:0] phase_rd;
    logic       pll_locked = 1'b0;
    logic [1:0] psel;
    logic       pdir, pstep, pload, rst_out_n, lock_lost;

    pll_phase_ctrl #(
        .NUM_CH(NCH), .STEPS_W(8), .PHASE_W(6), .SETUP_CYC(SETUP), .PULSE_CYC(PULSE),
        .GAP_CYC(GAP), .LOCK_STABLE(LS)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
        .cmd_ch_i(cmd_ch), .cmd_dir_i(cmd_dir), .cmd_steps_i(cmd_steps), .busy_o(busy),
        .done_o(done), .cmd_err_o(cmd_err), .phase_rd_ch_i(phase_rd_ch), .phase_rd_o(phase_rd),
        .pll_locked_i(pll_locked), .pll_phasesel_o(psel), .pll_phasedir_o(pdir),
        .pll_phasestep_o(pstep), .pll_phaseloadreg_o(pload), .rst_out_n_o(rst_out_n),
        .lock_lost_o(lock_lost)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit err;
        bit abort;
        int ch;
        int dir;
        int steps;
        int phase;
        int sel;
    } exp_t;

    exp_t sb_q[$];
    int   model[4];
    int   last_sel = 0;
    int   n_chk = 0;
    int   n_pass = 0;
    int   cyc = 0;
    int   done_cnt = 0;

    function automatic void chk(string name, int act, int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endfunction

    always @(posedge clk) cyc++;

    // Monitor: peeks the expected entry at handshake, compares and pops at done.
    exp_t cur;
    bit   in_seq = 0;
    logic prev_step = 1'b1;
    int   hs_cyc, busy_cnt, falls, low_cnt, load_cnt, sel_bad, first_fall;

    always @(negedge clk) begin
        if (!rst_n) begin
            in_seq = 0;
        end else begin
            if (in_seq) begin
                if (busy) busy_cnt++;
                if (!pstep) begin
                    low_cnt++;
                    if (int'(psel) != cur.ch || int'(pdir) != cur.dir) sel_bad++;
                    if (prev_step) begin
                        falls++;
                        if (falls == 1) first_fall = cyc - hs_cyc;
                    end
                end
                if (!pload) load_cnt++;
                if (done) begin
                    chk("cmd_err", int'(cmd_err), int'(cur.err));
                    chk("sel_hold", int'(psel), cur.sel);
                    if (cur.abort) begin
                        int d;
                        d = (int'(phase_rd) - cur.phase + 64) % 64;
                        chk("abort_phase_1or2", int'(d == 1 || d == 2), 1);
                        chk("abort_no_load", load_cnt, 0);
                    end else begin
                        int lat;
                        int nv;
                        nv = (cur.err || cur.steps == 0) ? 0 : cur.steps;
                        lat = (nv == 0) ? 1 : SETUP + nv * (PULSE + GAP) + PULSE + 1;
                        chk("done_latency", cyc - hs_cyc, lat);
                        chk("busy_len", busy_cnt, lat + 1);
                        chk("step_pulses", falls, nv);
                        chk("step_low_cycles", low_cnt, nv * PULSE);
                        chk("loadreg_cycles", load_cnt, (nv > 0) ? PULSE : 0);
                        chk("sel_dir_during_step", sel_bad, 0);
                        if (nv > 0) chk("first_fall", first_fall, SETUP + 1);
                        if (!cur.err) chk("phase_rd", int'(phase_rd), cur.phase);
                    end
                    void'(sb_q.pop_front());
                    in_seq = 0;
                    done_cnt++;
                end
            end
            if (cmd_valid && cmd_ready && sb_q.size() > 0) begin
                cur = sb_q[0];
                in_seq = 1;
                hs_cyc = cyc;
                busy_cnt = busy ? 1 : 0;
                falls = 0;
                low_cnt = 0;
                load_cnt = 0;
                sel_bad = 0;
                first_fall = -1;
            end
        end
        prev_step = pstep;
    end

    task automatic send(input int ch, input int dir, input int steps, input bit track,
                        input bit abort);
        exp_t e;
        int   n;
        @(posedge clk); #1;
        if (track) begin
            e.err   = (ch >= NCH);
            e.abort = abort;
            e.ch    = ch;
            e.dir   = dir;
            e.steps = steps;
            if (!e.err && steps > 0) last_sel = ch;
            e.sel   = last_sel;
            if (!e.err && !abort) model[ch] = ((model[ch] + (dir ? steps : -steps)) % 64 + 64) % 64;
            e.phase = (ch < NCH) ? model[ch] : 0;
            sb_q.push_back(e);
        end
        cmd_valid = 1'b1;
        cmd_ch = 2'(ch);
        cmd_dir = dir[0];
        cmd_steps = 8'(steps);
        phase_rd_ch = 2'(ch);
        n = 0;
        while (1) begin
            @(negedge clk);
            if (cmd_ready) break;
            n++;
            if (n > 200) begin
                chk("ready_timeout", 0, 1);
                if (track) void'(sb_q.pop_back());
                break;
            end
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int old);
        int n = 0;
        while (done_cnt == old && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        if (done_cnt == old) chk("done_timeout", 0, 1);
    endtask

    task automatic run_cmd(input int ch, input int dir, input int steps);
        int old = done_cnt;
        send(ch, dir, steps, 1'b1, 1'b0);
        wait_done(old);
    endtask

    task automatic measure_release(output int n);
        n = 0;
        while (!rst_out_n && n < 4 * LS + 50) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    initial begin
        int n, old, pf, ch, steps;
        logic prev;
        for (int i = 0; i < 4; i++) model[i] = 0;

        #23;
        chk("rst_cmd_ready", int'(cmd_ready), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_cmd_err", int'(cmd_err), 0);
        chk("rst_phasesel", int'(psel), 0);
        chk("rst_phasedir", int'(pdir), 0);
        chk("rst_phasestep", int'(pstep), 1);
        chk("rst_loadreg", int'(pload), 1);
        chk("rst_rst_out_n", int'(rst_out_n), 0);
        chk("rst_lock_lost", int'(lock_lost), 0);
        chk("rst_phase_rd", int'(phase_rd), 0);

        @(posedge clk); #1;
        rst_n = 1'b1;
        #1 chk("ready_before_first_edge", int'(cmd_ready), 0);
        @(posedge clk); #1;
        chk("ready_lock_low", int'(cmd_ready), int'(!LOCKMON));

        // Lock qualification, with a one-cycle glitch restarting the count.
        pll_locked = 1'b1;
        if (LOCKMON) begin
            repeat (30) @(posedge clk);
            #1 chk("rst_out_held_during_count", int'(rst_out_n), 0);
            pll_locked = 1'b0;
            @(posedge clk); #1;
            pll_locked = 1'b1;
        end
        measure_release(n);
        chk("lock_release_latency", n, LOCKMON ? LS + 2 : 2);
        chk("lock_lost_after_release", int'(lock_lost), 0);

        // Directed: three steps on ch2, wrap on ch0, error channel, zero steps.
        run_cmd(2, 1, 3);
        run_cmd(0, 0, 1);
        run_cmd(0, 1, 1);
        run_cmd(3, 1, 5);
        run_cmd(1, 1, 0);

        for (int k = 0; k < 30; k++) begin
            ch = $urandom_range(0, 3);
            steps = ($urandom_range(0, 7) == 0) ? $urandom_range(7, 20) : $urandom_range(0, 6);
            run_cmd(ch, $urandom_range(0, 1), steps);
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end

        // Lock drop during the second pulse of five.
        old = done_cnt;
        send(1, 1, 5, 1'b1, LOCKMON);
        pf = 0;
        prev = 1'b1;
        n = 0;
        while (pf < 2 && n < 200) begin
            @(posedge clk); #1;
            n++;
            if (!pstep && prev) pf++;
            prev = pstep;
        end
        pll_locked = 1'b0;
        wait_done(old);
        @(posedge clk); #1;
        chk("lock_lost_after_drop", int'(lock_lost), int'(LOCKMON));
        chk("rst_out_after_drop", int'(rst_out_n), 0);

        // Relock, then assert reset in the middle of a low pulse.
        pll_locked = 1'b1;
        measure_release(n);
        chk("relock_latency", n, LOCKMON ? LS + 2 : 2);
        send(0, 1, 4, 1'b0, 1'b0);
        n = 0;
        while (pstep && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("reached_step_lo", int'(pstep), 0);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_busy", int'(busy), 0);
        chk("arst_phasestep", int'(pstep), 1);
        chk("arst_loadreg", int'(pload), 1);
        chk("arst_phasesel", int'(psel), 0);
        chk("arst_phasedir", int'(pdir), 0);
        chk("arst_done", int'(done), 0);
        chk("arst_rst_out_n", int'(rst_out_n), 0);
        chk("arst_lock_lost", int'(lock_lost), 0);
        chk("arst_cmd_ready", int'(cmd_ready), 0);
        for (int i = 0; i < 4; i++) begin
            phase_rd_ch = 2'(i);
            #1 chk("arst_phase_rd", int'(phase_rd), 0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        chk("scoreboard_empty", sb_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/pll_phase_ctrl.md
# pll_phase_ctrl

Dynamic phase-shift and lock-supervision controller for the ECP5 EHXPLLL used in the clock-generation path. Accepts phase-adjust commands (channel, direction, step count) over a valid/ready handshake and drives PHASESEL/PHASEDIR/PHASESTEP/PHASELOADREG with guaranteed setup and pulse timing. Tracks the accumulated phase offset per output channel and produces a lock-qualified system reset. Sits between the PLL wrapper and the SoC reset/CSR logic, clocked from the PLL reference clock.

## Interface

- NUM_CH, 4: PLL output channels controllable (1..4: CLKOP, CLKOS, CLKOS2, CLKOS3)
- STEPS_W, 8: width of step count per command
- PHASE_W, 6: width of per-channel phase accumulator (wraps modulo 2^PHASE_W)
- SETUP_CYC, 2: cycles PHASESEL/PHASEDIR held stable before a step pulse (>=1)
- PULSE_CYC, 2: PHASESTEP low time in cycles (>=1)
- GAP_CYC, 4: PHASESTEP high time between pulses in cycles (>=1)
- LOCK_STABLE, 1024: consecutive synchronised-lock cycles before reset release

- clk  in  1  reference clock (PLL CLKI domain)
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  controller can accept command
- cmd_ch  in  2  target channel
- cmd_dir  in  1  1 = delay (+), 0 = advance (-)
- cmd_steps  in  STEPS_W  number of step pulses
- busy  out  1  sequence in progress
- done  out  1  one-cycle pulse at sequence end
- cmd_err  out  1  valid with done: command rejected or aborted
- phase_rd_ch  in  2  channel selector for readback
- phase_rd  out  PHASE_W  accumulated offset of phase_rd_ch (combinational mux)
- pll_locked  in  1  PLL LOCK (asynchronous)
- pll_phasesel  out  2  to PHASESEL1:0
- pll_phasedir  out  1  to PHASEDIR
- pll_phasestep  out  1  to PHASESTEP, idle high, pulses low
- pll_phaseloadreg  out  1  to PHASELOADREG, idle high, pulses low
- rst_out_n  out  1  lock-qualified system reset, active low
- lock_lost  out  1  sticky: lock dropped after reset release

## Operation

- pll_locked passes a 2-flop synchroniser (locked_s) before any use.
- FSM: IDLE -> SETUP -> STEP_LO -> STEP_HI -> (STEP_LO | LOAD) -> DONE -> IDLE.
- IDLE: cmd_ready=1 when rst_out_n=1 (macro on) or unconditionally (macro off). Handshake on cmd_valid&&cmd_ready latches ch/dir/steps.
- cmd_ch >= NUM_CH: go directly to DONE with cmd_err=1; pins untouched.
- cmd_steps == 0: go directly to DONE, cmd_err=0; pins untouched.
- SETUP: drive pll_phasesel=ch, pll_phasedir=dir for SETUP_CYC cycles.
- STEP_LO: pll_phasestep=0 for PULSE_CYC cycles; on leaving, accumulator[ch] +/-= 1 (mod 2^PHASE_W), remaining steps decremented.
- STEP_HI: pll_phasestep=1 for GAP_CYC cycles; remaining>0 -> STEP_LO, else LOAD.
- LOAD: pll_phaseloadreg=0 for PULSE_CYC cycles, then DONE.
- DONE: done=1 one cycle, busy=0 next cycle.
- pll_phasesel/pll_phasedir hold last value in IDLE.
- Reset values: cmd_ready=0 until first cycle out of reset, busy=0, done=0, cmd_err=0, pll_phasesel=0, pll_phasedir=0, pll_phasestep=1, pll_phaseloadreg=1, rst_out_n=0, lock_lost=0, all accumulators=0.
- Reset asserted mid-sequence: immediate return to reset values; PLL-side phase and accumulators diverge, software must re-run calibration.

## Timing

- Handshake cycle to first PHASESTEP fall: SETUP_CYC+1 cycles.
- Total busy length for N>0 steps: 1+SETUP_CYC+N*(PULSE_CYC+GAP_CYC)+PULSE_CYC+1 cycles; with defaults N=3 -> 24.
- Lock path latency: 2 cycles synchroniser + LOCK_STABLE counter.
- New command accepted earliest the cycle after done.

## Configuration

- PLL_PHASE_CTRL_LOCKMON_EN defined: rst_out_n released after LOCK_STABLE consecutive locked_s cycles; any locked_s=0 resets counter and reasserts rst_out_n next cycle, sets lock_lost if rst_out_n was 1; locked_s=0 during a sequence aborts it: pins return to idle next cycle, accumulator keeps only completed pulses, DONE with cmd_err=1; cmd_ready=0 while rst_out_n=0.
- Undefined: rst_out_n = locked_s, no abort, lock_lost tied 0, cmd_ready independent of lock.

## Test plan

- Lock rises at t0 (macro on) -> rst_out_n=1 exactly LOCK_STABLE+2 cycles later; glitch low at cycle 500 restarts count.
- cmd ch=2, dir=1, steps=3 -> three 2-cycle low pulses spaced 4 high, phasesel=2, one loadreg pulse, done after 24 cycles, phase_rd(ch2)=3.
- ch=0, dir=0, steps=1 from 0 -> phase_rd=63 (wrap); then dir=1 steps=1 -> 0.
- cmd ch=3 with NUM_CH=2 -> done+cmd_err next-but-one cycle, no pin activity; steps=0 -> done, cmd_err=0.
- Drop pll_locked during pulse 2 of 5 (macro on) -> abort, cmd_err=1, accumulator +1 or +2 per completed pulses, lock_lost=1, rst_out_n=0.
- rst_n asserted mid-STEP_LO -> all outputs at reset values asynchronously.
